vu_level_ctrl: RTL and testbench

- Sits between the UART receive path and the VGA renderer of the VU meter. Turns the stream of received sample bytes into a displayed bar level and a peak-hold marker.
- Accumulates the per-frame maximum magnitude and commits new level/peak values only at a frame boundary from the VGA timing, so the bar never tears mid-frame.
- Applies instant attack, linear decay, and a peak-hold timer with its own decay.

---
 rtl/vu_level_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vu_level_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vu_level_ctrl.sv
// VU meter level controller: per-frame max of received samples, committed
// at vertical blanking with instant attack, linear decay and peak hold.
module vu_level_ctrl #(
    parameter bit          SIGNED_IN        = 1'b0,
    parameter int unsigned DECAY_STEP       = 4,
    parameter int unsigned PEAK_DECAY       = 2,
    parameter int unsigned PEAK_HOLD_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    input  logic       sample_error,
    input  logic       frame_start,
    output logic [7:0] level,
    output logic [7:0] peak,
    output logic       level_update,
    output logic [3:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        PUBLISH
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] frame_max_q, frame_max_d;
    logic [7:0] snap_q, snap_d;
    logic [7:0] level_q, level_d;
    logic [7:0] peak_q, peak_d;
    logic [5:0] hold_q, hold_d;
    logic [3:0] err_q, err_d;
    logic       upd_q, upd_d;

    logic [7:0] abs8;
    logic [7:0] mag;
    logic       accepted;
    logic       errored;
    logic       start;

    logic [8:0] lvl_dec;
    logic [8:0] pk_dec;
    logic [7:0] lvl_dec_c;
    logic [7:0] pk_dec_c;
    logic [7:0] level_n;
    logic [7:0] peak_n;
    logic [5:0] hold_n;

    assign accepted = enable & sample_valid & ~sample_error;
    assign errored  = enable & sample_valid & sample_error;
    assign start    = enable & frame_start & (state_q == IDLE);

    // Signed input: |s|*2, where only -128 overflows 8 bits
    always_comb begin
        abs8 = sample[7] ? (8'd0 - sample) : sample;
        if (SIGNED_IN) begin
            mag = abs8[7] ? 8'hFF : {abs8[6:0], 1'b0};
        end else begin
            mag = sample;
        end
    end

    always_comb begin
        lvl_dec   = {1'b0, level_q} - 9'(DECAY_STEP);
        pk_dec    = {1'b0, peak_q} - 9'(PEAK_DECAY);
        lvl_dec_c = lvl_dec[8] ? 8'd0 : lvl_dec[7:0];
        pk_dec_c  = pk_dec[8] ? 8'd0 : pk_dec[7:0];

        if (snap_q >= level_q) begin
            level_n = snap_q;
        end else begin
            level_n = (snap_q > lvl_dec_c) ? snap_q : lvl_dec_c;
        end

        hold_n = hold_q;
        if (snap_q >= peak_q) begin
            peak_n = snap_q;
            hold_n = 6'(PEAK_HOLD_FRAMES);
        end else if (hold_q != 6'd0) begin
            peak_n = peak_q;
            hold_n = hold_q - 6'd1;
        end else begin
            peak_n = (level_n > pk_dec_c) ? level_n : pk_dec_c;
        end

        if (level_n > peak_n) begin
            peak_n = level_n;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_max_d = frame_max_q;
        snap_d      = snap_q;
        level_d     = level_q;
        peak_d      = peak_q;
        hold_d      = hold_q;
        err_d       = err_q;
        upd_d       = 1'b0;

        if (errored && err_q != 4'hF) begin
            err_d = err_q + 4'd1;
        end
        if (accepted && mag > frame_max_q) begin
            frame_max_d = mag;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d      = frame_max_q;
                    frame_max_d = accepted ? mag : 8'd0;
                    state_d     = CALC;
                end
            end
            CALC: begin
                level_d = level_n;
                peak_d  = peak_n;
                hold_d  = hold_n;
                upd_d   = 1'b1;
                state_d = PUBLISH;
            end
            PUBLISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            frame_max_q <= 8'd0;
            snap_q      <= 8'd0;
            level_q     <= 8'd0;
            peak_q      <= 8'd0;
            hold_q      <= 6'd0;
            err_q       <= 4'd0;
            upd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_max_q <= frame_max_d;
            snap_q      <= snap_d;
            level_q     <= level_d;
            peak_q      <= peak_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            upd_q       <= upd_d;
        end
    end

    assign level        = level_q;
    assign peak         = peak_q;
    assign level_update = upd_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_vu_level_ctrl.sv
// Bench for vu_level_ctrl: unsigned and signed instances share stimulus
// and are compared every cycle against a frame-level reference model.
module tb_vu_level_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] sample = 8'd0;
    logic       sample_valid = 1'b0;
    logic       sample_error = 1'b0;
    logic       frame_start = 1'b0;

    logic [7:0] lvl_u, pk_u, lvl_s, pk_s;
    logic       upd_u, upd_s;
    logic [3:0] ec_u, ec_s;

    int checks = 0;
    int errors = 0;

    // model state: index 0 = unsigned instance, 1 = signed instance
    int m_lvl[2];
    int m_pk[2];
    int m_hold[2];
    int m_snap[2];
    int m_err;
    int m_phase;
    int frame_q[$];

    vu_level_ctrl #(.SIGNED_IN(1'b0)) u_uns (
        .clock(clock), .reset(reset), .enable(enable),
        .sample(sample), .sample_valid(sample_valid),
        .sample_error(sample_error), .frame_start(frame_start),
        .level(lvl_u), .peak(pk_u), .level_update(upd_u),
        .err_count(ec_u)
    );

    vu_level_ctrl #(.SIGNED_IN(1'b1)) u_sgn (
        .clock(clock), .reset(reset), .enable(enable),
        .sample(sample), .sample_valid(sample_valid),
        .sample_error(sample_error), .frame_start(frame_start),
        .level(lvl_s), .peak(pk_s), .level_update(upd_s),
        .err_count(ec_s)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int mag_of(input int inst, input int b);
        int v;
        int m;
        if (inst == 0) return b;
        v = (b >= 128) ? b - 256 : b;
        m = 2 * ((v < 0) ? -v : v);
        return (m > 255) ? 255 : m;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lvl[i]  = 0;
            m_pk[i]   = 0;
            m_hold[i] = 0;
            m_snap[i] = 0;
        end
        m_err   = 0;
        m_phase = 0;
        frame_q.delete();
    endtask

    task automatic commit(input int i);
        int s;
        int ln;
        int pn;
        s  = m_snap[i];
        ln = (s >= m_lvl[i]) ? s : imax(s, imax(0, m_lvl[i] - 4));
        if (s >= m_pk[i]) begin
            pn = s;
            m_hold[i] = 30;
        end else if (m_hold[i] > 0) begin
            pn = m_pk[i];
            m_hold[i]--;
        end else begin
            pn = imax(ln, imax(0, m_pk[i] - 2));
        end
        m_lvl[i] = ln;
        m_pk[i]  = imax(pn, ln);
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_phase == 1) begin
            commit(0);
            commit(1);
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (enable && frame_start) begin
            for (int i = 0; i < 2; i++) begin
                m_snap[i] = 0;
                foreach (frame_q[k]) m_snap[i] = imax(m_snap[i], mag_of(i, frame_q[k]));
            end
            frame_q.delete();
            m_phase = 1;
        end
        if (enable && sample_valid) begin
            if (sample_error) m_err = (m_err < 15) ? m_err + 1 : 15;
            else frame_q.push_back(int'(sample));
        end
    endtask

    task automatic compare_all();
        chk("lvl_u", 16'(lvl_u), 16'(m_lvl[0]));
        chk("pk_u", 16'(pk_u), 16'(m_pk[0]));
        chk("upd_u", 16'(upd_u), 16'(m_phase == 2));
        chk("err_u", 16'(ec_u), 16'(m_err));
        chk("lvl_s", 16'(lvl_s), 16'(m_lvl[1]));
        chk("pk_s", 16'(pk_s), 16'(m_pk[1]));
        chk("upd_s", 16'(upd_s), 16'(m_phase == 2));
        chk("err_s", 16'(ec_s), 16'(m_err));
    endtask

    task automatic step(input bit sv, input logic [7:0] s, input bit se,
                        input bit fs);
        @(negedge clock);
        sample_valid = sv;
        sample       = s;
        sample_error = se;
        frame_start  = fs;
        if (!reset) model_reset();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b1);
            step(1'b0, 8'd0, 1'b0, 1'b0);
            step(1'b0, 8'd0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        model_reset();
        #2;
        compare_all();
        chk("rst_lvl", 16'(lvl_u), 16'd0);
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b1;

        // attack: 10, 200, 50 then commit two cycles after frame_start
        step(1'b1, 8'd10, 1'b0, 1'b0);
        step(1'b1, 8'd200, 1'b0, 1'b0);
        step(1'b1, 8'd50, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        chk("lat_n1_upd", 16'(upd_u), 16'd0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("attack_upd", 16'(upd_u), 16'd1);
        chk("attack_lvl", 16'(lvl_u), 16'd200);
        chk("attack_pk", 16'(pk_u), 16'd200);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("single_pulse", 16'(upd_u), 16'd0);

        // decay and hold expiry
        frame(30);
        chk("decay_lvl80", 16'(lvl_u), 16'd80);
        chk("hold_pk200", 16'(pk_u), 16'd200);
        frame(1);
        chk("decay_lvl76", 16'(lvl_u), 16'd76);
        chk("pk_decay198", 16'(pk_u), 16'd198);

        // signed magnitudes
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        frame(1);
        chk("sgn_c0", 16'(lvl_s), 16'd128);
        step(1'b1, 8'h80, 1'b0, 1'b0);
        frame(1);
        chk("sgn_80_lvl", 16'(lvl_s), 16'd255);
        chk("sgn_80_pk", 16'(pk_s), 16'd255);

        // sample coincident with frame_start goes to the new frame
        frame(70);
        chk("drained", 16'(lvl_u), 16'd0);
        step(1'b1, 8'd40, 1'b0, 1'b0);
        step(1'b1, 8'd90, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("coinc_40", 16'(lvl_u), 16'd40);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        frame(1);
        chk("coinc_90", 16'(lvl_u), 16'd90);

        // errored samples are counted and dropped
        repeat (3) step(1'b1, 8'd250, 1'b1, 1'b0);
        chk("err3", 16'(ec_u), 16'd3);
        frame(1);
        chk("err_nolift", 16'(lvl_u), 16'd86);
        repeat (20) step(1'b1, 8'd250, 1'b1, 1'b0);
        chk("err_sat", 16'(ec_u), 16'd15);

        // decay clamps at zero
        frame(30);
        step(1'b1, 8'd3, 1'b0, 1'b0);
        frame(1);
        chk("lvl3", 16'(lvl_u), 16'd3);
        frame(1);
        chk("clamp0", 16'(lvl_u), 16'd0);

        // reset during CALC
        step(1'b1, 8'd100, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst_calc_pk", 16'(pk_u), 16'd0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        chk("rst_calc_upd", 16'(upd_u), 16'd0);
        @(negedge clock);
        reset = 1'b1;

        // enable low gates frame_start and samples
        step(1'b1, 8'd120, 1'b0, 1'b0);
        enable = 1'b0;
        repeat (4) begin
            step(1'b1, 8'd255, 1'b1, 1'b1);
            step(1'b0, 8'd0, 1'b0, 1'b0);
            chk("en0_upd", 16'(upd_u), 16'd0);
        end
        enable = 1'b1;
        frame(1);
        chk("en0_kept", 16'(lvl_u), 16'd120);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 499) != 0);
            step($urandom_range(0, 9) < 3, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
